stopwatch_bcd_core: RTL and testbench
=====================================

# stopwatch_bcd_core

Timekeeping core of the stopwatch. It conditions the three raw push-buttons and runs a start/stop/lap state machine. It counts elapsed time in packed BCD as SS.hh: tens of seconds, seconds, tenths, hundredths. Its `number` output drives the 4-digit `Display_Digits` multiplexer directly (digit 0 = hundredths in bits [3:0]; the decimal point is lit on digit 2).

## Interface
- `CLK_HZ`, 100_000_000, system clock frequency.
- `TICK_HZ`, 100, count rate (hundredths). `CLK_HZ/TICK_HZ` must be an integer ≥ 2.
- `DEBOUNCE_CYCLES`, 1_000_000, consecutive stable cycles required to accept a button level change (≥ 1).

- `clk`  in  1  system clock, all flops rising-edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `btn_start`  in  1  raw start/stop button, asynchronous to `clk`.
- `btn_lap`  in  1  raw lap button, asynchronous.
- `btn_clear`  in  1  raw clear button, asynchronous.
- `number`  out  16  displayed time, 4 packed BCD digits, registered.
- `running`  out  1  high in RUNNING or LAP.
- `lap_active`  out  1  high in LAP (display frozen).
- `overflow`  out  1  sticky, set on wrap 99.99→00.00.

## Operation
- **Button conditioning**, per button:
  - 2-flop synchronizer.
  - Debounce counter resets whenever the synchronized level equals the accepted level. Otherwise it increments. On reaching `DEBOUNCE_CYCLES`, the accepted level takes the new value and the counter clears.
  - Press event: 1-cycle pulse on an accepted 0→1 transition. Release generates nothing. Holding the button produces one event only.
- **Prescaler**:
  - Counts 0..CLK_HZ/TICK_HZ−1 while `running`, then emits a 1-cycle `tick` at the terminal count and wraps to 0.
  - Holds its value in STOPPED, so pause/resume keeps the sub-hundredth fraction.
  - Zeroed by clear.
- **Time counter**: four BCD digits d3..d0, incremented on `tick`.
  - d0 wraps 9→0 and carries into d1. The same ripple applies to d1→d2 and d2→d3.
  - 99.99 + tick gives 00.00 and sets `overflow`.
  - Digits never hold values > 9.
- **Lap register**: 16 bits, loaded with the live time when entering LAP.
- **FSM** (reset state STOPPED):
  - STOPPED:
    - start → RUNNING.
    - clear → time = 0, prescaler = 0, overflow = 0.
    - lap is ignored.
  - RUNNING:
    - start → STOPPED.
    - lap → LAP, and the lap register captures the live time on the same edge.
    - clear is ignored.
  - LAP (counting continues):
    - lap → RUNNING.
    - start → STOPPED.
    - clear is ignored.
- **Simultaneous events** in one cycle: only the highest-priority event acts. Priority is start > lap > clear.
- **Output mux**: `number` = lap register in LAP, otherwise the live time.

## Timing
- **Reset values**:
  - Outputs: `number` = 16'h0000, `running` = 0, `lap_active` = 0, `overflow` = 0.
  - Internal: all debounce and accepted levels 0, prescaler 0, lap register 0, FSM STOPPED.
- **Reset mid-operation**: everything returns to the reset values immediately (asynchronous). The first count resumes only after a new start press.
- **Button latency**: let the first `clk` edge at which the new raw level is sampled be edge N. The accepted level changes at edge N+2+DEBOUNCE_CYCLES−1. The press pulse is high during the following cycle. The FSM state and `running` update at the edge that ends the pulse.
- **Glitches**: a raw glitch shorter than `DEBOUNCE_CYCLES` cycles produces no event.
- **Tick cadence**: in RUNNING/LAP, exactly one tick per CLK_HZ/TICK_HZ cycles. The live time updates on the edge that samples `tick`.
- **Output latency**: `number` is registered, one cycle behind the live value or lap mux.
- **Start at the tick cycle**: if start arrives in the cycle a tick is asserted, the tick is still counted. The machine then enters STOPPED.
- **Overflow**: `overflow` rises in the same cycle that the live time becomes 00.00.

## Test plan
Bench parameters: CLK_HZ = 1000, TICK_HZ = 100 (divider 10), DEBOUNCE_CYCLES = 4.
- **Reset/idle**: assert `rst` mid-count, then release with buttons low for 200 cycles → `number` = 0000, `running` = 0, `overflow` = 0 throughout.
- **Debounce**:
  - A 3-cycle start pulse → no state change.
  - Start held for 50 cycles → exactly one event; `running` = 1, first increment 10 cycles later.
  - Button bounce 1-0-1 within 3 cycles before settling high → a single event.
- **Count/carry**: run for 1000 ticks → `number` = 16'h1000 (10.00). Check intermediate values 0009→0010 and 0099→0100 at tick boundaries.
- **Pause/resume fraction**: stop 4 cycles after a tick, wait 100 cycles, restart → next increment after 6 more running cycles; `number` is unchanged while stopped.
- **Lap**: press lap at 0250 → `number` frozen at 0250 and `lap_active` = 1 while the live count continues. Press lap again after 50 more ticks → `number` shows 0300 (±1 tick).
- **Overflow/clear/priority**:
  - Run past 9999 → `number` = 0000 and `overflow` = 1.
  - Clear while running → ignored.
  - Start and clear events in the same cycle while STOPPED → RUNNING, no clear.
  - Stop, then clear → `number` = 0000, `overflow` = 0.

Source files
------------

// File: rtl/stopwatch_bcd_core.sv
// Stopwatch timekeeping core: three debounced buttons, a start/stop/lap FSM,
// a tick prescaler and a 4-digit packed-BCD SS.hh time counter.
module stopwatch_bcd_core #(
  parameter int CLK_HZ          = 100_000_000,
  parameter int TICK_HZ         = 100,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_start,
  input  logic        btn_lap,
  input  logic        btn_clear,
  output logic [15:0] number,
  output logic        running,
  output logic        lap_active,
  output logic        overflow
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam int DW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
  localparam logic [DW-1:0] DB_MAX    = DW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ST_STOPPED = 2'd0;
  localparam logic [1:0] ST_RUNNING = 2'd1;
  localparam logic [1:0] ST_LAP     = 2'd2;

  // Button vectors: bit 0 = start, bit 1 = lap, bit 2 = clear.
  logic [2:0]    btn_raw;
  logic [2:0]    sync1_q, sync1_d, sync2_q, sync2_d;
  logic [2:0]    level_q, level_d, press_q, press_d;
  logic [DW-1:0] db_cnt_q [3];
  logic [DW-1:0] db_cnt_d [3];

  logic [1:0]    state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   time_q, time_d, lap_q, lap_d, number_q, number_d;
  logic          ovf_q, ovf_d;
  logic          ev_start, ev_lap, ev_clear, run, tick, carry;

  assign btn_raw = {btn_clear, btn_lap, btn_start};

  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    level_d = level_q;
    press_d = '0;
    for (int i = 0; i < 3; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (db_cnt_q[i] == DB_MAX) begin
          level_d[i] = sync2_q[i];
          press_d[i] = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DW'(1);
        end
      end
    end
  end

  // Only the highest-priority pending event is allowed to act.
  assign ev_start = press_q[0];
  assign ev_lap   = press_q[1] & ~press_q[0];
  assign ev_clear = press_q[2] & ~press_q[1] & ~press_q[0];

  assign run  = (state_q != ST_STOPPED);
  assign tick = run && (presc_q == PRESC_MAX);

  always_comb begin
    time_d  = time_q;
    ovf_d   = ovf_q;
    presc_d = presc_q;
    state_d = state_q;
    lap_d   = lap_q;
    carry   = tick;
    for (int k = 0; k < 4; k++) begin
      if (carry) begin
        if (time_q[4*k +: 4] == 4'd9) begin
          time_d[4*k +: 4] = 4'd0;
        end else begin
          time_d[4*k +: 4] = time_q[4*k +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    if (carry) ovf_d = 1'b1;
    if (run) presc_d = tick ? '0 : presc_q + PW'(1);

    case (state_q)
      ST_STOPPED: begin
        if (ev_start) begin
          state_d = ST_RUNNING;
        end else if (ev_clear) begin
          time_d  = '0;
          presc_d = '0;
          ovf_d   = 1'b0;
        end
      end
      ST_RUNNING: begin
        if (ev_start) begin
          state_d = ST_STOPPED;
        end else if (ev_lap) begin
          state_d = ST_LAP;
          lap_d   = time_q;
        end
      end
      ST_LAP: begin
        if (ev_start)    state_d = ST_STOPPED;
        else if (ev_lap) state_d = ST_RUNNING;
      end
      default: state_d = ST_STOPPED;
    endcase

    number_d = (state_q == ST_LAP) ? lap_q : time_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      level_q  <= '0;
      press_q  <= '0;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
      state_q  <= ST_STOPPED;
      presc_q  <= '0;
      time_q   <= '0;
      lap_q    <= '0;
      number_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      level_q  <= level_d;
      press_q  <= press_d;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= db_cnt_d[i];
      state_q  <= state_d;
      presc_q  <= presc_d;
      time_q   <= time_d;
      lap_q    <= lap_d;
      number_q <= number_d;
      ovf_q    <= ovf_d;
    end
  end

  assign number     = number_q;
  assign running    = run;
  assign lap_active = (state_q == ST_LAP);
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_stopwatch_bcd_core.sv
// Bench for stopwatch_bcd_core: a divide-by-10 instance for the main plan and a
// divide-by-2 instance so the full 99.99 wrap fits in a short run.
module tb_stopwatch_bcd_core;

  localparam int DB = 4;

  typedef struct {
    int             state;  // 0 stopped, 1 running, 2 lap
    int             presc;
    int             tm;     // live time in hundredths
    int             lap;
    int             num;    // value shown on the display
    bit             ovf;
    bit [2:0]       acc;
    bit [2:0]       press;
    bit [2:0][DB+1:0] hist; // recent raw samples, bit 0 newest
  } model_t;

  logic clk, rst;
  logic bs, bl, bc, os, ol, oc;
  logic [15:0] n_m, n_o;
  logic r_m, l_m, o_m, r_o, l_o, o_o;

  int checks, failures;
  logic [18:0] exp_q[$];
  logic [18:0] exp_o_q[$];
  model_t mm, mo;

  stopwatch_bcd_core #(.CLK_HZ(1000), .TICK_HZ(100), .DEBOUNCE_CYCLES(DB)) u_dut (
    .clk(clk), .rst(rst), .btn_start(bs), .btn_lap(bl), .btn_clear(bc),
    .number(n_m), .running(r_m), .lap_active(l_m), .overflow(o_m)
  );

  stopwatch_bcd_core #(.CLK_HZ(200), .TICK_HZ(100), .DEBOUNCE_CYCLES(DB)) u_ovf (
    .clk(clk), .rst(rst), .btn_start(os), .btn_lap(ol), .btn_clear(oc),
    .number(n_o), .running(r_o), .lap_active(l_o), .overflow(o_o)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic model_t m_reset();
    model_t r;
    r.state = 0; r.presc = 0; r.tm = 0; r.lap = 0; r.num = 0;
    r.ovf = 1'b0; r.acc = '0; r.press = '0; r.hist = '0;
    return r;
  endfunction

  function automatic model_t m_step(input model_t s, input bit [2:0] raw, input int div);
    model_t n;
    bit run, tick;
    bit [DB+1:0] h;
    n = s;
    run  = (s.state != 0);
    tick = run && (s.presc == div - 1);
    n.num = (s.state == 2) ? s.lap : s.tm;
    if (tick) begin
      n.tm = (s.tm + 1) % 10000;
      if (s.tm == 9999) n.ovf = 1'b1;
    end
    if (run) n.presc = tick ? 0 : s.presc + 1;
    if (s.press[0]) begin
      n.state = (s.state == 0) ? 1 : 0;
    end else if (s.press[1]) begin
      if (s.state == 1) begin
        n.state = 2;
        n.lap = s.tm;
      end else if (s.state == 2) begin
        n.state = 1;
      end
    end else if (s.press[2] && s.state == 0) begin
      n.tm = 0; n.presc = 0; n.ovf = 1'b0;
    end
    // A level is accepted once the synchronised input has differed for DB samples.
    for (int b = 0; b < 3; b++) begin
      h = {s.hist[b][DB:0], raw[b]};
      n.hist[b] = h;
      n.press[b] = 1'b0;
      if (h[DB+1:2] == {DB{~s.acc[b]}}) begin
        n.acc[b] = ~s.acc[b];
        n.press[b] = ~s.acc[b];
      end
    end
    return n;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int bcd_to_int(input logic [15:0] b);
    return b[15:12] * 1000 + b[11:8] * 100 + b[7:4] * 10 + b[3:0];
  endfunction

  function automatic logic [18:0] exp_of(input model_t m);
    return {to_bcd(m.num), m.state != 0, m.state == 2, m.ovf};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mm = m_reset();
      mo = m_reset();
      exp_q.delete();
      exp_o_q.delete();
    end else begin
      mm = m_step(mm, {bc, bl, bs}, 10);
      mo = m_step(mo, {oc, ol, os}, 2);
      exp_q.push_back(exp_of(mm));
      exp_o_q.push_back(exp_of(mo));
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic mon_one(input int which);
    logic [18:0] act, exp;
    act = which ? {n_o, r_o, l_o, o_o} : {n_m, r_m, l_m, o_m};
    if (rst) begin
      check(which ? "reset_outs_o" : "reset_outs_m", 32'(act), 32'h0);
    end else if (which == 0) begin
      if (exp_q.size() == 0) check("queue_empty_m", 32'd0, 32'd1);
      else begin exp = exp_q.pop_front(); check("model_m", 32'(act), 32'(exp)); end
    end else begin
      if (exp_o_q.size() == 0) check("queue_empty_o", 32'd0, 32'd1);
      else begin exp = exp_o_q.pop_front(); check("model_o", 32'(act), 32'(exp)); end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      mon_one(0);
      mon_one(1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_raw(input int which, input int b, input logic v);
    if (which == 0) begin
      case (b) 0: bs = v; 1: bl = v; default: bc = v; endcase
    end else begin
      case (b) 0: os = v; 1: ol = v; default: oc = v; endcase
    end
  endtask

  task automatic press(input int which, input int b, input int hold);
    @(negedge clk);
    set_raw(which, b, 1'b1);
    repeat (hold) @(negedge clk);
    set_raw(which, b, 1'b0);
  endtask

  task automatic wait_num(input logic [15:0] v, input int budget, input string nm);
    int k;
    k = 0;
    while (n_m !== v && k < budget) begin
      @(posedge clk); #1; k++;
    end
    check(nm, 32'(n_m), 32'(v));
  endtask

  task automatic step_after(input logic [15:0] from, input logic [15:0] to, input string nm);
    int k;
    k = 0;
    do begin
      @(posedge clk); #1; k++;
    end while (n_m === from && k < 50);
    check({nm, "_value"}, 32'(n_m), 32'(to));
    check({nm, "_cycles"}, 32'(k), 32'd10);
  endtask

  // ---------------- stimulus ----------------
  task automatic main_thread();
    logic [15:0] v;
    int diff, mask, hold, gap;
    press(0, 0, 3);
    cycles(20);
    check("glitch_3cyc_no_event", 32'(r_m), 32'd0);

    @(negedge clk); bs = 1'b1;
    cycles(10);
    check("hold_start_running", 32'(r_m), 32'd1);
    cycles(40); bs = 1'b0;
    cycles(20);
    check("hold_single_event", 32'(r_m), 32'd1);

    press(0, 0, 8); cycles(20);
    check("stop_running", 32'(r_m), 32'd0);
    press(0, 2, 8); cycles(20);
    check("clear_number", 32'(n_m), 32'd0);

    @(negedge clk); bs = 1'b1;
    @(negedge clk); bs = 1'b0;
    @(negedge clk); bs = 1'b1;
    cycles(10); bs = 1'b0;
    cycles(20);
    check("bounce_single_event", 32'(r_m), 32'd1);

    wait_num(16'h0009, 400, "reach_0009");
    step_after(16'h0009, 16'h0010, "carry_d1");
    wait_num(16'h0099, 1500, "reach_0099");
    step_after(16'h0099, 16'h0100, "carry_d2");
    wait_num(16'h1000, 12000, "reach_1000");

    press(0, 0, 8); cycles(30);
    v = n_m;
    cycles(100);
    check("hold_while_stopped", 32'(n_m), 32'(v));
    press(0, 0, 8); cycles(30);
    check("resume_running", 32'(r_m), 32'd1);

    // Second lap press is raised exactly 500 cycles after the first: 50 ticks apart.
    @(negedge clk); bl = 1'b1;
    cycles(8); bl = 1'b0;
    cycles(20);
    v = n_m;
    check("lap_active", 32'(l_m), 32'd1);
    cycles(100);
    check("lap_frozen", 32'(n_m), 32'(v));
    cycles(372);
    bl = 1'b1;
    cycles(8); bl = 1'b0;
    cycles(20);
    check("lap_released", 32'(l_m), 32'd0);
    diff = bcd_to_int(n_m) - bcd_to_int(v);
    check("lap_delta_50_ticks", 32'(diff >= 50 && diff <= 53), 32'd1);

    for (int i = 0; i < 250; i++) begin
      mask = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : (1 << $urandom_range(0, 2));
      hold = $urandom_range(1, 12);
      gap  = $urandom_range(0, 25);
      @(negedge clk);
      bs = mask[0]; bl = mask[1]; bc = mask[2];
      cycles(hold);
      bs = 1'b0; bl = 1'b0; bc = 1'b0;
      cycles(gap);
    end
    cycles(30);
  endtask

  task automatic ovf_thread();
    int k;
    press(1, 0, 8); cycles(20);
    check("o_running", 32'(r_o), 32'd1);
    press(1, 2, 8); cycles(20);
    check("o_clear_ignored_running", 32'(r_o), 32'd1);
    check("o_clear_ignored_number", 32'(n_o != 16'h0000), 32'd1);

    k = 0;
    while (o_o !== 1'b1 && k < 25000) begin
      @(posedge clk); #1; k++;
    end
    check("o_overflow_set", 32'(o_o), 32'd1);
    @(posedge clk); #1;
    check("o_wrap_0000", 32'(n_o), 32'h0000);

    press(1, 0, 8); cycles(20);
    check("o_stopped", 32'(r_o), 32'd0);
    check("o_overflow_sticky", 32'(o_o), 32'd1);

    @(negedge clk); os = 1'b1; oc = 1'b1;
    cycles(8); os = 1'b0; oc = 1'b0;
    cycles(20);
    check("o_prio_start_wins", 32'(r_o), 32'd1);
    check("o_prio_no_clear", 32'(o_o), 32'd1);

    press(1, 0, 8); cycles(20);
    press(1, 2, 8); cycles(20);
    check("o_final_clear_number", 32'(n_o), 32'h0000);
    check("o_final_clear_overflow", 32'(o_o), 32'd0);
    check("o_final_stopped", 32'(r_o), 32'd0);
  endtask

  initial begin
    checks = 0; failures = 0;
    bs = 0; bl = 0; bc = 0; os = 0; ol = 0; oc = 0;
    rst = 1'b1;
    cycles(3);
    rst = 1'b0;

    press(0, 0, 8);
    cycles(60);
    check("running_before_reset", 32'(r_m), 32'd1);
    rst = 1'b1;
    cycles(3);
    rst = 1'b0;
    cycles(200);
    check("idle_number", 32'(n_m), 32'h0000);
    check("idle_running", 32'(r_m), 32'd0);
    check("idle_overflow", 32'(o_m), 32'd0);

    fork
      main_thread();
      ovf_thread();
    join

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
